// File: rtl/tt_example_pkg.sv
// Shared constants for the TinyTapeout example adder tile.
//   WIDTH     : operand/sum width fixed by the TT pinout
//   ZERO_BYTE : reset value of the sum register and tie value for unused pins
package tt_example_pkg;

  localparam int unsigned WIDTH = 8;

  localparam logic [WIDTH-1:0] ZERO_BYTE = WIDTH'(0);

endpackage : tt_example_pkg

// File: rtl/tt_um_example_adder_add_w.sv
// Combinational WIDTH-bit unsigned adder with carry-out.
//   a, b : unsigned operands
//   sum  : (a + b) mod 2^WIDTH
//   cout : carry out of the top bit
module add_w
  import tt_example_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Extend both operands by one bit so the carry lands in the MSB.
  assign {cout, sum} = (WIDTH+1)'(a) + (WIDTH+1)'(b);

endmodule : add_w

// File: rtl/tt_um_example_adder.sv
// TinyTapeout user tile: registered 8-bit modulo-256 adder.
//   clk     : rising-edge clock
//   rst_n   : synchronous reset, ACTIVE-HIGH despite the name (harness naming)
//   ena     : tile enable; the sum register only loads while high
//   ui_in   : operand A
//   uio_in  : operand B (all bidir pins used as inputs)
//   uo_out  : registered sum, one cycle after the operands
//   uio_out : unused, tied low
//   uio_oe  : bidir enables, tied low so every uio pin is an input
module tt_um_example_adder
  import tt_example_pkg::*;
(
`ifdef GL_TEST
  input  wire              VPWR,
  input  wire              VGND,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe
);

  logic [WIDTH-1:0] sum_c;
  logic             cout_unused;
  logic [WIDTH-1:0] sum_q;

  // Adder datapath; the carry-out is intentionally dropped (modulo-256 result).
  add_w u_add (
    .a    (ui_in),
    .b    (uio_in),
    .sum  (sum_c),
    .cout (cout_unused)
  );

  // Sum register: reset wins over enable, hold while disabled.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sum_q <= ZERO_BYTE;
    end else if (ena) begin
      sum_q <= sum_c;
    end
  end

  assign uo_out  = sum_q;
  assign uio_out = ZERO_BYTE;
  assign uio_oe  = ZERO_BYTE;

endmodule : tt_um_example_adder

// File: tb/tb_tt_um_example_adder.sv
module tb_tt_um_example_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int nvec = 0;
  int nerr = 0;
  int model_q = 0;   // reference register value, plain integer arithmetic

  tt_um_example_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, updating the reference with the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b1)   model_q = 0;
    else if (ena === 1'b1) model_q = (int'(ui_in) + int'(uio_in)) % 256;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h12; uio_in = 8'h34;
    tick();
    tick();
    nvec++;
    if (uo_out !== 8'h00) begin
      nerr++; $display("FAIL reset_uo_out: got %h expected 00", uo_out);
    end
    nvec++;
    if (uio_oe !== 8'h00) begin
      nerr++; $display("FAIL reset_uio_oe: got %h expected 00", uio_oe);
    end
    nvec++;
    if (uio_out !== 8'h00) begin
      nerr++; $display("FAIL reset_uio_out: got %h expected 00", uio_out);
    end
  endtask

  task automatic test_basic_add();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'd20; uio_in = 8'd30;
    #2;
    nvec++;
    if (uo_out !== 8'd0) begin
      nerr++; $display("FAIL basic_before_edge: got %0d expected 0", uo_out);
    end
    tick();
    nvec++;
    if (uo_out !== 8'd50) begin
      nerr++; $display("FAIL basic_add: got %0d expected 50", uo_out);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] av [3] = '{8'hFF, 8'hFF, 8'h80};
    logic [7:0] bv [3] = '{8'h01, 8'hFF, 8'h80};
    logic [7:0] ev [3] = '{8'h00, 8'hFE, 8'h00};
    for (int i = 0; i < 3; i++) begin
      ui_in = av[i]; uio_in = bv[i];
      tick();
      nvec++;
      if (uo_out !== ev[i]) begin
        nerr++;
        $display("FAIL wrap_%0d: %h+%h got %h expected %h", i, av[i], bv[i], uo_out, ev[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    ena = 1'b1; ui_in = 8'd5; uio_in = 8'd6;
    tick();
    nvec++;
    if (uo_out !== 8'd11) begin
      nerr++; $display("FAIL hold_settle: got %0d expected 11", uo_out);
    end
    ena = 1'b0; ui_in = 8'd100; uio_in = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (uo_out !== 8'd11) begin
        nerr++; $display("FAIL hold_cycle_%0d: got %0d expected 11", i, uo_out);
      end
    end
    ena = 1'b1;
    tick();
    nvec++;
    if (uo_out !== 8'd101) begin
      nerr++; $display("FAIL hold_release: got %0d expected 101", uo_out);
    end
  endtask

  task automatic test_reset_mid();
    int exp_sum;
    ena = 1'b1; rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ui_in = 8'($urandom); uio_in = 8'($urandom);
      tick();
      nvec++;
      if (uo_out !== 8'(model_q)) begin
        nerr++; $display("FAIL mid_stream_%0d: got %h expected %h", i, uo_out, 8'(model_q));
      end
    end
    rst_n = 1'b1; ui_in = 8'($urandom); uio_in = 8'($urandom);
    tick();
    nvec++;
    if (uo_out !== 8'h00) begin
      nerr++; $display("FAIL mid_reset: got %h expected 00", uo_out);
    end
    rst_n = 1'b0; ui_in = 8'($urandom); uio_in = 8'($urandom);
    exp_sum = (int'(ui_in) + int'(uio_in)) % 256;
    tick();
    nvec++;
    if (uo_out !== 8'(exp_sum)) begin
      nerr++; $display("FAIL mid_release: got %h expected %h", uo_out, 8'(exp_sum));
    end
  endtask

  task automatic test_random();
    rst_n = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      ena    = ($urandom_range(0, 3) != 0);
      tick();
      nvec++;
      if (uo_out !== 8'(model_q) || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        nerr++;
        $display("FAIL random_%0d: uo_out=%h uio_out=%h uio_oe=%h expected %h/00/00",
                 i, uo_out, uio_out, uio_oe, 8'(model_q));
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; ui_in = '0; uio_in = '0;
    test_reset();
    test_basic_add();
    test_wrap();
    test_enable_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_tt_um_example_adder
